// File: rtl/cache_axi_arb_if.sv
// Signal bundle between the two caches, the arbiter and the cache-to-AXI bridge.
// slave is the arbiter's view; master is the view of everything around it.
interface cache_axi_arb_if;
  logic         i_rd_req;
  logic [2:0]   i_rd_type;
  logic [31:0]  i_rd_addr;
  logic         i_rd_rdy;
  logic         i_ret_valid;
  logic         i_ret_last;
  logic [31:0]  i_ret_data;

  logic         d_rd_req;
  logic [2:0]   d_rd_type;
  logic [31:0]  d_rd_addr;
  logic         d_rd_rdy;
  logic         d_ret_valid;
  logic         d_ret_last;
  logic [31:0]  d_ret_data;

  logic         d_wr_req;
  logic [31:0]  d_wr_addr;
  logic [127:0] d_wr_data;
  logic         d_wr_rdy;

  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;

  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport slave (
    input  i_rd_req, i_rd_type, i_rd_addr,
    output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    input  d_rd_req, d_rd_type, d_rd_addr,
    output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    input  d_wr_req, d_wr_addr, d_wr_data,
    output d_wr_rdy,
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output wr_req, wr_addr, wr_data,
    input  wr_rdy
  );

  modport master (
    output i_rd_req, i_rd_type, i_rd_addr,
    input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    output d_rd_req, d_rd_type, d_rd_addr,
    input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    output d_wr_req, d_wr_addr, d_wr_data,
    input  d_wr_rdy,
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  wr_req, wr_addr, wr_data,
    output wr_rdy
  );
endinterface

// File: rtl/cache_axi_arb.sv
// Round-robin read arbiter (one outstanding read) plus a one-entry dirty-line write buffer
// for the shared cache-to-AXI bridge; reads to the buffered line stall until it drains.
module cache_axi_arb #(
  parameter int LINE_OFS = 4
) (
  input  logic              clk,
  input  logic              reset,
  cache_axi_arb_if.slave    bus
);

  localparam int LW = 32 - LINE_OFS;

  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_WAIT} r_state_t;
  typedef enum logic       {W_EMPTY, W_FULL}        w_state_t;

  r_state_t     r_state, r_next;
  w_state_t     w_state, w_next;
  logic         owner;        // 0 = icache, 1 = dcache
  logic         last_grant;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;

  logic [LW-1:0] i_line, d_line, wb_line, dw_line, held_line;
  logic          i_elig, d_elig, grant_d;
  logic          sel_d, issue, issue_fire;
  logic          rd_req_c, i_rd_rdy_c, d_rd_rdy_c;
  logic [2:0]    rd_type_c;
  logic [31:0]   rd_addr_c;
  logic          d_wr_rdy_c, wr_acc;

  assign i_line    = bus.i_rd_addr[31:LINE_OFS];
  assign d_line    = bus.d_rd_addr[31:LINE_OFS];
  assign wb_line   = wb_addr[31:LINE_OFS];
  assign dw_line   = bus.d_wr_addr[31:LINE_OFS];
  assign held_line = owner ? d_line : i_line;

  // A read to the line sitting in the write buffer must not overtake the write.
  assign i_elig  = bus.i_rd_req & ((w_state == W_EMPTY) | (i_line != wb_line));
  assign d_elig  = bus.d_rd_req & ((w_state == W_EMPTY) | (d_line != wb_line));
  assign grant_d = d_elig & (~i_elig | ~last_grant);

  always_comb begin
    r_next     = r_state;
    sel_d      = owner;
    issue      = 1'b0;
    issue_fire = 1'b0;
    rd_req_c   = 1'b0;
    i_rd_rdy_c = 1'b0;
    d_rd_rdy_c = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (i_elig | d_elig) begin
          issue      = 1'b1;
          sel_d      = grant_d;
          rd_req_c   = 1'b1;
          issue_fire = bus.rd_rdy;
          r_next     = bus.rd_rdy ? R_WAIT : R_HOLD;
        end
      end
      R_HOLD: begin
        sel_d      = owner;
        rd_req_c   = 1'b1;
        issue_fire = bus.rd_rdy;
        if (bus.rd_rdy) r_next = R_WAIT;
      end
      R_WAIT: begin
        if (bus.ret_valid & bus.ret_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
    i_rd_rdy_c = rd_req_c & ~sel_d & bus.rd_rdy;
    d_rd_rdy_c = rd_req_c &  sel_d & bus.rd_rdy;
    rd_addr_c  = rd_req_c ? (sel_d ? bus.d_rd_addr : bus.i_rd_addr) : 32'h0;
    rd_type_c  = rd_req_c ? (sel_d ? bus.d_rd_type : bus.i_rd_type) : 3'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= R_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      r_state <= r_next;
      if (issue)      owner      <= sel_d;
      if (issue_fire) last_grant <= sel_d;
    end
  end

  // Refuse a write-back to the line a stalled-at-bridge read is about to fetch.
  assign d_wr_rdy_c = (w_state == W_EMPTY) &
                      ~((r_state == R_HOLD) & (held_line == dw_line));
  assign wr_acc     = bus.d_wr_req & d_wr_rdy_c;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_EMPTY: if (wr_acc)     w_next = W_FULL;
      W_FULL:  if (bus.wr_rdy) w_next = W_EMPTY;
      default: w_next = W_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_EMPTY;
      wb_addr <= 32'h0;
      wb_data <= 128'h0;
    end else begin
      w_state <= w_next;
      if (wr_acc) begin
        wb_addr <= bus.d_wr_addr;
        wb_data <= bus.d_wr_data;
      end
    end
  end

  // Every output is forced low while reset is asserted, independent of the clock.
  assign bus.rd_req      = ~reset & rd_req_c;
  assign bus.rd_type     = reset ? 3'h0 : rd_type_c;
  assign bus.rd_addr     = reset ? 32'h0 : rd_addr_c;
  assign bus.i_rd_rdy    = ~reset & i_rd_rdy_c;
  assign bus.d_rd_rdy    = ~reset & d_rd_rdy_c;

  assign bus.i_ret_valid = ~reset & bus.ret_valid & (r_state == R_WAIT) & ~owner;
  assign bus.i_ret_last  = ~reset & bus.ret_last  & (r_state == R_WAIT) & ~owner;
  assign bus.d_ret_valid = ~reset & bus.ret_valid & (r_state == R_WAIT) &  owner;
  assign bus.d_ret_last  = ~reset & bus.ret_last  & (r_state == R_WAIT) &  owner;
  assign bus.i_ret_data  = reset ? 32'h0 : bus.ret_data;
  assign bus.d_ret_data  = reset ? 32'h0 : bus.ret_data;

  assign bus.d_wr_rdy    = ~reset & d_wr_rdy_c;
  assign bus.wr_req      = ~reset & (w_state == W_FULL);
  assign bus.wr_addr     = reset ? 32'h0 : wb_addr;
  assign bus.wr_data     = reset ? 128'h0 : wb_data;

endmodule

// File: tb/tb_cache_axi_arb.sv
// Directed bench for cache_axi_arb: inputs change 1 time unit after the rising edge,
// outputs are compared 1 time unit later, well before the next rising edge.
module tb_cache_axi_arb;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  localparam logic [31:0]  I_ADDR  = 32'h1C00_0040;
  localparam logic [31:0]  D_ADDR  = 32'h0000_3000;
  localparam logic [127:0] WB_DATA = 128'h0123_4567_89AB_CDEF_0000_1111_0000_DEAD;

  cache_axi_arb_if bus ();

  cache_axi_arb #(.LINE_OFS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four return beats base..base+3 for the given owner; nothing may be issued meanwhile.
  task automatic beats(input bit to_d, input logic [31:0] base, input string tag);
    for (int k = 0; k < 4; k++) begin
      bus.ret_valid = 1'b1;
      bus.ret_last  = (k == 3);
      bus.ret_data  = base + k;
      #1;
      check({tag, "_own_valid"}, to_d ? bus.d_ret_valid : bus.i_ret_valid, 1'b1);
      check({tag, "_oth_valid"}, to_d ? bus.i_ret_valid : bus.d_ret_valid, 1'b0);
      check({tag, "_last"},      to_d ? bus.d_ret_last  : bus.i_ret_last,  (k == 3));
      check({tag, "_data"},      to_d ? bus.d_ret_data  : bus.i_ret_data,  base + k);
      check({tag, "_no_rd_req"}, bus.rd_req, 1'b0);
      tick();
    end
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.ret_data  = 32'h0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.i_rd_req = 1'b1; bus.i_rd_type = 3'd4; bus.i_rd_addr = I_ADDR;
    bus.d_rd_req = 1'b0; bus.d_rd_type = 3'd2; bus.d_rd_addr = D_ADDR;
    bus.d_wr_req = 1'b0; bus.d_wr_addr = 32'h0; bus.d_wr_data = 128'h0;
    bus.rd_rdy = 1'b1; bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
    bus.ret_data = 32'h55; bus.wr_rdy = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_rd_req",   bus.rd_req,     1'b0);
    check("rst_i_rd_rdy", bus.i_rd_rdy,   1'b0);
    check("rst_d_wr_rdy", bus.d_wr_rdy,   1'b0);
    check("rst_i_ret_dat", bus.i_ret_data, 32'h0);
    check("rst_wr_req",   bus.wr_req,     1'b0);
    tick(); tick();
    reset = 1'b0;

    // Tie after reset: dcache first, then icache.
    bus.d_rd_req = 1'b1;
    #1;
    check("tie_rd_addr", bus.rd_addr,  D_ADDR);
    check("tie_rd_type", bus.rd_type,  3'd2);
    check("tie_d_rdy",   bus.d_rd_rdy, 1'b1);
    check("tie_i_rdy",   bus.i_rd_rdy, 1'b0);
    tick();
    bus.d_rd_req = 1'b0;
    #1;
    check("wait_i_rdy", bus.i_rd_rdy, 1'b0);
    beats(1'b1, 32'hD0, "tie_d");
    #1;
    check("tie2_rd_addr", bus.rd_addr,  I_ADDR);
    check("tie2_i_rdy",   bus.i_rd_rdy, 1'b1);
    tick();
    bus.i_rd_req = 1'b0;
    beats(1'b0, 32'hA0, "icache");
    bus.ret_valid = 1'b1;
    #1;
    check("idle_ret_ignored", bus.i_ret_valid | bus.d_ret_valid, 1'b0);
    bus.ret_valid = 1'b0;

    // Hold stability: icache stuck behind rd_rdy low, dcache arrives meanwhile.
    bus.rd_rdy = 1'b0; bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h1C00_0080;
    #1;
    check("hold1_addr", bus.rd_addr,  32'h1C00_0080);
    check("hold1_irdy", bus.i_rd_rdy, 1'b0);
    tick();
    bus.d_rd_req = 1'b1;
    #1;
    check("hold2_addr", bus.rd_addr,  32'h1C00_0080);
    check("hold2_req",  bus.rd_req,   1'b1);
    tick();
    #1;
    check("hold3_addr", bus.rd_addr, 32'h1C00_0080);
    tick();
    bus.rd_rdy = 1'b1;
    #1;
    check("hold4_irdy", bus.i_rd_rdy, 1'b1);
    check("hold4_drdy", bus.d_rd_rdy, 1'b0);
    tick();
    bus.i_rd_req = 1'b0;
    beats(1'b0, 32'hB0, "hold_i");
    #1;
    check("hold_next_addr", bus.rd_addr,  D_ADDR);
    check("hold_next_drdy", bus.d_rd_rdy, 1'b1);
    tick();
    bus.d_rd_req = 1'b0;
    beats(1'b1, 32'hB8, "hold_d");

    // Write buffer and read-after-write hazard.
    bus.wr_rdy = 1'b0; bus.d_wr_req = 1'b1;
    bus.d_wr_addr = 32'h0000_1230; bus.d_wr_data = WB_DATA;
    #1;
    check("wb_accept", bus.d_wr_rdy, 1'b1);
    check("wb_no_req", bus.wr_req,   1'b0);
    tick();
    bus.d_wr_req = 1'b0;
    bus.d_rd_req = 1'b1; bus.d_rd_addr = 32'h0000_1234;
    #1;
    check("wb_req",      bus.wr_req,   1'b1);
    check("wb_addr",     bus.wr_addr,  32'h0000_1230);
    check("wb_data",     bus.wr_data,  WB_DATA);
    check("wb_full_rdy", bus.d_wr_rdy, 1'b0);
    check("raw_stall1",  bus.rd_req,   1'b0);
    tick();
    #1;
    check("raw_stall2", bus.rd_req, 1'b0);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h0000_2000;
    #1;
    check("raw_i_addr", bus.rd_addr,  32'h0000_2000);
    check("raw_i_rdy",  bus.i_rd_rdy, 1'b1);
    check("raw_d_rdy",  bus.d_rd_rdy, 1'b0);
    tick();
    bus.i_rd_req = 1'b0;
    beats(1'b0, 32'hC0, "raw_i");
    #1;
    check("raw_stall3", bus.rd_req,   1'b0);
    check("wb_still",   bus.d_wr_rdy, 1'b0);
    bus.wr_rdy = 1'b1;
    #1;
    check("drain_no_acc", bus.d_wr_rdy, 1'b0);
    check("drain_stall",  bus.rd_req,   1'b0);
    tick();
    bus.wr_rdy = 1'b0;
    #1;
    check("drained_req",  bus.wr_req,   1'b0);
    check("drained_rdy",  bus.d_wr_rdy, 1'b1);
    check("raw_issue",    bus.rd_req,   1'b1);
    check("raw_addr",     bus.rd_addr,  32'h0000_1234);
    check("raw_d_rdy2",   bus.d_rd_rdy, 1'b1);
    tick();
    bus.d_rd_req = 1'b0;
    beats(1'b1, 32'hE0, "raw_d");

    // Write refused while a held read targets the same line.
    bus.rd_rdy = 1'b0; bus.d_rd_req = 1'b1; bus.d_rd_addr = 32'h0000_4440;
    tick();
    bus.d_wr_req = 1'b1; bus.d_wr_addr = 32'h0000_4448;
    #1;
    check("hold_wr_block", bus.d_wr_rdy, 1'b0);
    bus.d_wr_req = 1'b0;
    bus.rd_rdy = 1'b1;
    tick();
    bus.d_rd_req = 1'b0;
    beats(1'b1, 32'hF0, "blk_d");

    // Mid-read reset during beat 2.
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h1C00_00C0;
    tick();
    bus.i_rd_req = 1'b0;
    bus.ret_valid = 1'b1; bus.ret_data = 32'h90; bus.ret_last = 1'b0;
    tick();
    bus.ret_data = 32'h91; bus.i_rd_req = 1'b1;
    reset = 1'b1;
    #1;
    check("mrst_ret_valid", bus.i_ret_valid, 1'b0);
    check("mrst_ret_data",  bus.i_ret_data,  32'h0);
    check("mrst_rd_req",    bus.rd_req,      1'b0);
    check("mrst_i_rdy",     bus.i_rd_rdy,    1'b0);
    tick();
    reset = 1'b0; bus.ret_valid = 1'b0; bus.ret_data = 32'h0;
    bus.i_rd_addr = 32'h1C00_0100;
    #1;
    check("post_rst_addr", bus.rd_addr,  32'h1C00_0100);
    check("post_rst_irdy", bus.i_rd_rdy, 1'b1);
    tick();
    bus.i_rd_req = 1'b0;
    beats(1'b0, 32'h70, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
